speck32_iter_ctrl: RTL
======================

# speck32_iter_ctrl

Iterative SPECK32/64 encryption controller that time-multiplexes a single 16-bit MIG XOR word unit and a single 16-bit adder across all round and key-schedule operations. It accepts one plaintext/key pair over a valid/ready handshake and runs 22 rounds with 4 phases each. It returns the ciphertext over a second valid/ready handshake. It is the sequencing layer above the MIG/mMIG/AOIG word-level datapath blocks in the SPECK core.

## Interface
- WORD, 16: datapath word width (fixed for SPECK32).
- ROUNDS, 22: number of cipher rounds.
- ROT_A, 7: right-rotate amount applied to x and l.
- ROT_B, 2: left-rotate amount applied to y and k.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  plaintext/key pair offered.
- in_ready  out  1  high only in IDLE.
- pt  in  32  plaintext; x = pt[31:16], y = pt[15:0].
- key  in  64  key; {l2, l1, l0, k0} = {key[63:48], key[47:32], key[31:16], key[15:0]}.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer accepts ciphertext.
- ct  out  32  ciphertext {x, y}.
- round_idx  out  5  current round number, 0..21 (observability only).

## Operation
- FSM states: IDLE, RUN, DONE. Within RUN, a 2-bit phase counter P0..P3 and a 5-bit round counter.
- IDLE, in_valid=1: load x, y, k=k0 and the l queue (l0, l1, l2). Set round=0, phase=P0, state=RUN. pt and key are sampled only on this edge; later changes have no effect.
- Each phase has one adder operation and one XOR operation, both 16-bit. The adder wraps mod 2^16. The XOR runs on the single shared XOR unit.
  - P0: x <= (ROR(x,7) + y) ^ k.
  - P1: y <= ROL(y,2) ^ x. Uses the x written in P0.
  - P2: l2_new = (k + ROR(l0,7)) ^ {11'b0, round}. Then shift the queue: l0 <= l1, l1 <= l2, l2 <= l2_new.
  - P3: k <= ROL(k,2) ^ l2. Uses the l2 written in P2.
- Phase wraps P3 -> P0 and increments round. At round 21 P3, go to DONE. The key update still runs in the last round; the result is discarded.
- DONE: out_valid=1 and ct={x,y}, held stable until out_ready=1. On the handshake edge, go to IDLE.
- in_valid is ignored (in_ready=0) in RUN and DONE. out_ready has no effect outside DONE.
- Operand muxes select the adder and XOR inputs by phase. No other XOR or adder instances exist in the block.

## Timing
- Reset values (first edge with rst_n=0): state IDLE, phase P0, round 0, round_idx 0, out_valid 0, ct 0, x/y/k/l cleared. After that edge, in_ready=1.
- rst_n low mid-RUN or in DONE aborts the operation on that edge. No ciphertext is produced.
- Outputs are registered or decoded from state. There are no combinational paths from in_valid or out_ready to any output.
- Latency: accept edge at cycle 0. RUN occupies cycles 1..88. out_valid rises at cycle 89.
- round_idx = r during cycles 4r+1..4r+4.
- If out_ready=1 at cycle 89, in_ready=1 at cycle 90. Minimum spacing between accepts is 90 cycles.

## Structure
- Shared package speck_pkg holds:
  - WORD, ROUNDS, ROT_A, ROT_B.
  - State enum {IDLE, RUN, DONE}.
  - Phase enum {P0..P3}.
  - rol/ror functions.
  - The 64-bit key and 32-bit plaintext/ciphertext field slicing constants.
- Natural sub-module: speck_round_mux, a combinational block that selects adder and XOR operands by phase. It feeds one instance of the team's 16-bit MIG XOR word unit, XOR_MIG.
- The FSM, counters and state registers stay in speck32_iter_ctrl.

## Test plan
- Known-answer test: key=64'h1918_1110_0908_0100, pt=32'h6574_694c -> ct=32'ha868_42f2, with out_valid rising exactly at cycle 89.
- Two back-to-back encryptions, out_ready tied high -> second accept at cycle 90, second out_valid at cycle 179, both ciphertexts correct.
- Backpressure: out_ready=0 for cycles 89..99, then 1 -> ct stable at 32'ha868_42f2 throughout, in_ready=0 until cycle 101.
- Input disturbance: toggle pt/key and pulse in_valid during cycles 1..88 -> no second accept, ct still 32'ha868_42f2.
- Reset at round 10 (cycle 42): rst_n=0 for one edge -> out_valid=0, round_idx=0, in_ready=1 on the next cycle. A following known-answer run yields 32'ha868_42f2.
- Round counter: round_idx=0 at cycle 1, 21 at cycles 85..88, 0 in DONE and IDLE after reset. No value above 21 ever appears.

Source files
------------

// File: rtl/speck_pkg.sv
// Shared SPECK32/64 constants, state encodings and word helpers for the iterative core.
package speck_pkg;

    localparam int unsigned WORD   = 16;
    localparam int unsigned ROUNDS = 22;
    localparam int unsigned ROT_A  = 7;
    localparam int unsigned ROT_B  = 2;
    localparam int unsigned RND_W  = 5;
    localparam int unsigned PT_W   = 32;
    localparam int unsigned KEY_W  = 64;

    // Field positions inside the plaintext/ciphertext and key buses
    localparam int unsigned X_LSB  = 16;
    localparam int unsigned Y_LSB  = 0;
    localparam int unsigned K0_LSB = 0;
    localparam int unsigned L0_LSB = 16;
    localparam int unsigned L1_LSB = 32;
    localparam int unsigned L2_LSB = 48;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;

    function automatic logic [WORD-1:0] ror(input logic [WORD-1:0] v, input int unsigned n);
        return (v >> n) | (v << (WORD - n));
    endfunction

    function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] v, input int unsigned n);
        return (v << n) | (v >> (WORD - n));
    endfunction

    function automatic logic [WORD-1:0] maj(input logic [WORD-1:0] a, input logic [WORD-1:0] b,
                                            input logic [WORD-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/speck32_iter_ctrl_if.sv
// Plaintext/key request and ciphertext response handshakes of the iterative SPECK controller.
interface speck32_iter_ctrl_if;
    import speck_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [PT_W-1:0]      pt;
    logic [KEY_W-1:0]     key;
    logic                 out_valid;
    logic                 out_ready;
    logic [PT_W-1:0]      ct;
    logic [RND_W-1:0]     round_idx;

    modport master (output in_valid, pt, key, out_ready,
                    input  in_ready, out_valid, ct, round_idx);
    modport slave  (input  in_valid, pt, key, out_ready,
                    output in_ready, out_valid, ct, round_idx);
endinterface

// File: rtl/speck_round_mux.sv
// Per-phase operand selection for the shared adder and XOR unit.
module speck_round_mux
    import speck_pkg::*;
(
    input  phase_t           phase,
    input  logic [WORD-1:0]  x,
    input  logic [WORD-1:0]  y,
    input  logic [WORD-1:0]  k,
    input  logic [WORD-1:0]  l0,
    input  logic [WORD-1:0]  l2,
    input  logic [RND_W-1:0] round,
    output logic [WORD-1:0]  add_a_c,
    output logic [WORD-1:0]  add_b_c,
    output logic [WORD-1:0]  xor_b_c
);
    // Phases without an addition pass their operand through with a zero addend
    always_comb begin
        add_a_c = '0;
        add_b_c = '0;
        xor_b_c = '0;
        case (phase)
            P0: begin
                add_a_c = ror(x, ROT_A);
                add_b_c = y;
                xor_b_c = k;
            end
            P1: begin
                add_a_c = rol(y, ROT_B);
                xor_b_c = x;
            end
            P2: begin
                add_a_c = k;
                add_b_c = ror(l0, ROT_A);
                xor_b_c = WORD'(round);
            end
            P3: begin
                add_a_c = rol(k, ROT_B);
                xor_b_c = l2;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/xor_mig.sv
// 16-bit XOR word unit built from majority gates: xor = M(~M(a,b,0), M(a,b,1), 0).
module xor_mig
    import speck_pkg::*;
(
    input  logic [WORD-1:0] a,
    input  logic [WORD-1:0] b,
    output logic [WORD-1:0] y_c
);
    logic [WORD-1:0] and_ab;
    logic [WORD-1:0] or_ab;

    assign and_ab = maj(a, b, {WORD{1'b0}});
    assign or_ab  = maj(a, b, {WORD{1'b1}});
    assign y_c    = maj(~and_ab, or_ab, {WORD{1'b0}});
endmodule

// File: rtl/speck32_iter_ctrl.sv
// Iterative SPECK32/64 encryptor: one adder and one XOR unit sequenced over 22 rounds x 4 phases.
module speck32_iter_ctrl
    import speck_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    speck32_iter_ctrl_if.slave  bus
);
    state_t             state, state_nxt;
    phase_t             phase, phase_nxt;
    logic [RND_W-1:0]   round, round_nxt;
    logic [WORD-1:0]    x, x_nxt, y, y_nxt, k, k_nxt;
    logic [WORD-1:0]    l0, l0_nxt, l1, l1_nxt, l2, l2_nxt;
    logic [PT_W-1:0]    ct, ct_nxt;
    logic               in_ready_q, out_valid_q;
    logic [WORD-1:0]    add_a_c, add_b_c, xor_b_c, sum_c, res_c;

    speck_round_mux u_mux (
        .phase   (phase),
        .x       (x),
        .y       (y),
        .k       (k),
        .l0      (l0),
        .l2      (l2),
        .round   (round),
        .add_a_c (add_a_c),
        .add_b_c (add_b_c),
        .xor_b_c (xor_b_c)
    );

    assign sum_c = add_a_c + add_b_c;

    xor_mig u_xor (
        .a   (sum_c),
        .b   (xor_b_c),
        .y_c (res_c)
    );

    // Next-state, datapath write-back and ciphertext capture
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        round_nxt = round;
        x_nxt     = x;
        y_nxt     = y;
        k_nxt     = k;
        l0_nxt    = l0;
        l1_nxt    = l1;
        l2_nxt    = l2;
        ct_nxt    = ct;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nxt = RUN;
                    phase_nxt = P0;
                    round_nxt = '0;
                    x_nxt     = bus.pt[X_LSB +: WORD];
                    y_nxt     = bus.pt[Y_LSB +: WORD];
                    k_nxt     = bus.key[K0_LSB +: WORD];
                    l0_nxt    = bus.key[L0_LSB +: WORD];
                    l1_nxt    = bus.key[L1_LSB +: WORD];
                    l2_nxt    = bus.key[L2_LSB +: WORD];
                end
            end
            RUN: begin
                case (phase)
                    P0: x_nxt = res_c;
                    P1: y_nxt = res_c;
                    P2: begin
                        l0_nxt = l1;
                        l1_nxt = l2;
                        l2_nxt = res_c;
                    end
                    P3: k_nxt = res_c;
                    default: ;
                endcase
                phase_nxt = phase_t'(2'(phase + 2'd1));
                if (phase == P3) begin
                    if (round == RND_W'(ROUNDS - 1)) begin
                        // x and y are final here; the last key update is dropped
                        state_nxt = DONE;
                        round_nxt = '0;
                        ct_nxt    = {x, y};
                    end else begin
                        round_nxt = round + RND_W'(1);
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            phase       <= P0;
            round       <= '0;
            x           <= '0;
            y           <= '0;
            k           <= '0;
            l0          <= '0;
            l1          <= '0;
            l2          <= '0;
            ct          <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            phase       <= phase_nxt;
            round       <= round_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            k           <= k_nxt;
            l0          <= l0_nxt;
            l1          <= l1_nxt;
            l2          <= l2_nxt;
            ct          <= ct_nxt;
            in_ready_q  <= (state_nxt == IDLE);
            out_valid_q <= (state_nxt == DONE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ct        = ct;
    assign bus.round_idx = round;
endmodule
